// File: rtl/router_ctrl_if.sv
// router_ctrl_if: source/FIFO/destination signals of the router controller.
// slave = controller side (router_ctrl), master = environment side (source, FIFOs, register block).
interface router_ctrl_if;
  logic       pkt_valid;
  logic [7:0] data_in;
  logic [2:0] fifo_full;
  logic [2:0] fifo_empty;
  logic [2:0] read_enb;
  logic       parity_done;
  logic       low_pkt_valid;
  logic [2:0] write_enb;
  logic       fifo_full_sel;
  logic [2:0] vld_out;
  logic [2:0] soft_reset;
  logic       busy;
  logic       detect_add;
  logic       lfd_state;
  logic       ld_state;
  logic       laf_state;
  logic       full_state;
  logic       write_enb_reg;
  logic       rst_int_reg;
  modport slave (
    input  pkt_valid, data_in, fifo_full, fifo_empty, read_enb, parity_done, low_pkt_valid,
    output write_enb, fifo_full_sel, vld_out, soft_reset, busy, detect_add, lfd_state,
           ld_state, laf_state, full_state, write_enb_reg, rst_int_reg
  );
  modport master (
    output pkt_valid, data_in, fifo_full, fifo_empty, read_enb, parity_done, low_pkt_valid,
    input  write_enb, fifo_full_sel, vld_out, soft_reset, busy, detect_add, lfd_state,
           ld_state, laf_state, full_state, write_enb_reg, rst_int_reg
  );
endinterface

// File: rtl/router_ctrl.sv
// router_ctrl: packet router FSM, FIFO write steering and per-FIFO idle-read soft reset.
// Ports: clk, rstn (sync active-low); b = router_ctrl_if.slave carrying source, FIFO flags,
// read enables, write enables, vld_out, soft_reset and the registered FSM status strobes.
module router_ctrl #(
  parameter int SOFT_RST_CYCLES = 30
) (
  input  logic          clk,
  input  logic          rstn,
  router_ctrl_if.slave  b
);
  typedef enum logic [2:0] {
    DECODE_ADDRESS,
    LOAD_FIRST_DATA,
    LOAD_DATA,
    FIFO_FULL_STATE,
    LOAD_AFTER_FULL,
    LOAD_PARITY,
    CHECK_PARITY_ERROR,
    WAIT_TILL_EMPTY
  } state_t;
  localparam logic [4:0] TC = 5'(SOFT_RST_CYCLES - 1);
  localparam logic [7:0] FLAGS_RST = 8'b0100_0000;
  state_t          state_q, state_d;
  logic [1:0]      addr_q, addr_d;
  logic [2:0][4:0] cnt_q, cnt_d;
  logic [2:0]      sr_q, sr_d;
  logic [7:0]      flags_q, flags_d;
  logic [3:0]      empty4, full4, sr4, oh;
  logic [1:0]      din_addr;
  logic            fsel;
  // Padding to four entries lets address 3 index safely and read as "absent".
  assign empty4   = {1'b0, b.fifo_empty};
  assign full4    = {1'b0, b.fifo_full};
  assign sr4      = {1'b0, sr_q};
  assign oh       = 4'b1 << addr_q;
  assign din_addr = b.data_in[1:0];
  assign fsel     = full4[addr_q];
  always_comb begin
    state_d = state_q;
    case (state_q)
      DECODE_ADDRESS:     state_d = (b.pkt_valid && din_addr != 2'd3)
                                    ? (empty4[din_addr] ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY)
                                    : DECODE_ADDRESS;
      LOAD_FIRST_DATA:    state_d = LOAD_DATA;
      LOAD_DATA:          state_d = fsel ? FIFO_FULL_STATE : !b.pkt_valid ? LOAD_PARITY : LOAD_DATA;
      FIFO_FULL_STATE:    state_d = fsel ? FIFO_FULL_STATE : LOAD_AFTER_FULL;
      LOAD_AFTER_FULL:    state_d = b.parity_done ? DECODE_ADDRESS
                                  : b.low_pkt_valid ? LOAD_PARITY : LOAD_DATA;
      LOAD_PARITY:        state_d = CHECK_PARITY_ERROR;
      CHECK_PARITY_ERROR: state_d = fsel ? FIFO_FULL_STATE : DECODE_ADDRESS;
      WAIT_TILL_EMPTY:    state_d = empty4[addr_q] ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
    endcase
    // A soft reset of the FIFO being written abandons the packet.
    if (sr4[addr_q] && state_q != DECODE_ADDRESS) state_d = DECODE_ADDRESS;
    addr_d  = (flags_q[6] && b.pkt_valid) ? din_addr : addr_q;
    // Status strobes are decoded from the next state so they register in step with it.
    flags_d = {state_d != DECODE_ADDRESS && state_d != LOAD_DATA,
               state_d == DECODE_ADDRESS,
               state_d == LOAD_FIRST_DATA,
               state_d == LOAD_DATA,
               state_d == LOAD_AFTER_FULL,
               state_d == FIFO_FULL_STATE,
               state_d inside {LOAD_DATA, LOAD_PARITY, LOAD_AFTER_FULL},
               state_d == CHECK_PARITY_ERROR};
    for (int i = 0; i < 3; i++) begin
      sr_d[i]  = !b.fifo_empty[i] && !b.read_enb[i] && cnt_q[i] == TC;
      cnt_d[i] = (b.fifo_empty[i] || b.read_enb[i] || cnt_q[i] == TC) ? 5'd0 : cnt_q[i] + 5'd1;
    end
  end
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= DECODE_ADDRESS;
      addr_q  <= 2'd0;
      cnt_q   <= '0;
      sr_q    <= 3'b000;
      flags_q <= FLAGS_RST;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      flags_q <= flags_d;
    end
  end
  assign b.write_enb     = flags_q[1] ? oh[2:0] : 3'b000;
  assign b.fifo_full_sel = fsel;
  assign b.vld_out       = ~b.fifo_empty;
  assign b.soft_reset    = sr_q;
  assign b.busy          = flags_q[7];
  assign b.detect_add    = flags_q[6];
  assign b.lfd_state     = flags_q[5];
  assign b.ld_state      = flags_q[4];
  assign b.laf_state     = flags_q[3];
  assign b.full_state    = flags_q[2];
  assign b.write_enb_reg = flags_q[1];
  assign b.rst_int_reg   = flags_q[0];
endmodule

// File: tb/tb_router_ctrl.sv
// tb_router_ctrl: directed vector table plus hand sequences for soft reset and override.
module tb_router_ctrl;
  localparam logic [7:0] S_DA  = 8'b0100_0000;
  localparam logic [7:0] S_LFD = 8'b1010_0000;
  localparam logic [7:0] S_LD  = 8'b0001_0010;
  localparam logic [7:0] S_FFS = 8'b1000_0100;
  localparam logic [7:0] S_LAF = 8'b1000_1010;
  localparam logic [7:0] S_LP  = 8'b1000_0010;
  localparam logic [7:0] S_CPE = 8'b1000_0001;
  localparam logic [7:0] S_WTE = 8'b1000_0000;
  typedef struct {
    logic       rstn;
    logic       pv;
    logic [7:0] din;
    logic [2:0] full;
    logic [2:0] empty;
    logic       pd;
    logic       lpv;
    logic [2:0] we;
    logic [7:0] st;
    logic       fsel;
  } vec_t;
  logic clk = 0;
  logic rstn = 1;
  int   n_chk = 0;
  int   n_fail = 0;
  vec_t vecs[$];
  router_ctrl_if bus();
  router_ctrl #(.SOFT_RST_CYCLES(30)) dut (.clk(clk), .rstn(rstn), .b(bus));
  always #5 clk = ~clk;
  wire [7:0] st = {bus.busy, bus.detect_add, bus.lfd_state, bus.ld_state,
                   bus.laf_state, bus.full_state, bus.write_enb_reg, bus.rst_int_reg};
  function automatic vec_t mk(logic r, logic pv, logic [7:0] din, logic [2:0] full, logic [2:0] empty,
                              logic pd, logic lpv, logic [2:0] we, logic [7:0] s, logic fsel);
    vec_t v;
    v = '{r, pv, din, full, empty, pd, lpv, we, s, fsel};
    return v;
  endfunction
  task automatic chk(string name, logic [7:0] act, logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(logic r, logic pv, logic [7:0] din, logic [2:0] full, logic [2:0] empty,
                       logic [2:0] rd, logic pd, logic lpv);
    rstn = r;
    bus.pkt_valid = pv;
    bus.data_in = din;
    bus.fifo_full = full;
    bus.fifo_empty = empty;
    bus.read_enb = rd;
    bus.parity_done = pd;
    bus.low_pkt_valid = lpv;
  endtask
  initial begin
    drive(1'b0, 1'b0, 8'h00, 3'b000, 3'b111, 3'b000, 1'b0, 1'b0);
    //             rstn pv  din    full    empty   pd   lpv  we      state  fsel
    vecs.push_back(mk(0, 0, 8'h00, 3'b000, 3'b111, 0, 0, 3'b000, S_DA,  0));
    vecs.push_back(mk(1, 1, 8'h05, 3'b000, 3'b111, 0, 0, 3'b000, S_LFD, 0));
    vecs.push_back(mk(1, 1, 8'h11, 3'b000, 3'b111, 0, 0, 3'b010, S_LD,  0));
    vecs.push_back(mk(1, 1, 8'h22, 3'b000, 3'b111, 0, 0, 3'b010, S_LD,  0));
    vecs.push_back(mk(1, 1, 8'h33, 3'b001, 3'b111, 0, 0, 3'b010, S_LD,  0));
    vecs.push_back(mk(1, 0, 8'h44, 3'b000, 3'b111, 0, 0, 3'b010, S_LP,  0));
    vecs.push_back(mk(1, 0, 8'h00, 3'b000, 3'b111, 0, 0, 3'b000, S_CPE, 0));
    vecs.push_back(mk(1, 0, 8'h00, 3'b000, 3'b111, 0, 0, 3'b000, S_DA,  0));
    vecs.push_back(mk(1, 1, 8'h03, 3'b000, 3'b111, 0, 0, 3'b000, S_DA,  0));
    vecs.push_back(mk(1, 0, 8'h00, 3'b111, 3'b111, 0, 0, 3'b000, S_DA,  0));
    vecs.push_back(mk(1, 1, 8'h00, 3'b000, 3'b111, 0, 0, 3'b000, S_LFD, 0));
    vecs.push_back(mk(1, 1, 8'h10, 3'b000, 3'b111, 0, 0, 3'b001, S_LD,  0));
    vecs.push_back(mk(1, 1, 8'h20, 3'b001, 3'b111, 0, 0, 3'b000, S_FFS, 1));
    vecs.push_back(mk(1, 1, 8'h20, 3'b001, 3'b111, 0, 0, 3'b000, S_FFS, 1));
    vecs.push_back(mk(1, 1, 8'h20, 3'b000, 3'b111, 0, 0, 3'b001, S_LAF, 0));
    vecs.push_back(mk(1, 1, 8'h30, 3'b000, 3'b111, 0, 0, 3'b001, S_LD,  0));
    vecs.push_back(mk(1, 0, 8'h40, 3'b000, 3'b111, 0, 0, 3'b001, S_LP,  0));
    vecs.push_back(mk(1, 0, 8'h00, 3'b001, 3'b111, 0, 0, 3'b000, S_CPE, 1));
    vecs.push_back(mk(1, 0, 8'h00, 3'b001, 3'b111, 0, 0, 3'b000, S_FFS, 1));
    vecs.push_back(mk(1, 0, 8'h00, 3'b000, 3'b111, 0, 0, 3'b001, S_LAF, 0));
    vecs.push_back(mk(1, 0, 8'h00, 3'b000, 3'b111, 1, 0, 3'b000, S_DA,  0));
    vecs.push_back(mk(1, 1, 8'h02, 3'b000, 3'b011, 0, 0, 3'b000, S_WTE, 0));
    vecs.push_back(mk(1, 1, 8'h02, 3'b000, 3'b011, 0, 0, 3'b000, S_WTE, 0));
    vecs.push_back(mk(1, 1, 8'h02, 3'b000, 3'b111, 0, 0, 3'b000, S_LFD, 0));
    vecs.push_back(mk(1, 1, 8'h55, 3'b000, 3'b111, 0, 0, 3'b100, S_LD,  0));
    vecs.push_back(mk(1, 1, 8'h66, 3'b100, 3'b111, 0, 0, 3'b000, S_FFS, 1));
    vecs.push_back(mk(1, 0, 8'h66, 3'b000, 3'b111, 0, 0, 3'b100, S_LAF, 0));
    vecs.push_back(mk(1, 0, 8'h77, 3'b000, 3'b111, 0, 1, 3'b100, S_LP,  0));
    vecs.push_back(mk(1, 0, 8'h00, 3'b000, 3'b111, 0, 0, 3'b000, S_CPE, 0));
    vecs.push_back(mk(1, 0, 8'h00, 3'b000, 3'b111, 0, 0, 3'b000, S_DA,  0));
    vecs.push_back(mk(1, 1, 8'h01, 3'b000, 3'b111, 0, 0, 3'b000, S_LFD, 0));
    vecs.push_back(mk(1, 1, 8'h88, 3'b000, 3'b111, 0, 0, 3'b010, S_LD,  0));
    vecs.push_back(mk(0, 1, 8'h99, 3'b000, 3'b111, 0, 0, 3'b000, S_DA,  0));
    vecs.push_back(mk(1, 0, 8'h00, 3'b000, 3'b111, 0, 0, 3'b000, S_DA,  0));
    foreach (vecs[k]) begin
      drive(vecs[k].rstn, vecs[k].pv, vecs[k].din, vecs[k].full, vecs[k].empty, 3'b000,
            vecs[k].pd, vecs[k].lpv);
      tick();
      chk($sformatf("vec%0d write_enb", k), {5'b0, bus.write_enb}, {5'b0, vecs[k].we});
      chk($sformatf("vec%0d status", k), st, vecs[k].st);
      chk($sformatf("vec%0d fifo_full_sel", k), {7'b0, bus.fifo_full_sel}, {7'b0, vecs[k].fsel});
      chk($sformatf("vec%0d vld_out", k), {5'b0, bus.vld_out}, {5'b0, ~vecs[k].empty});
      chk($sformatf("vec%0d soft_reset", k), {5'b0, bus.soft_reset}, 8'h00);
    end
    // 30 unread cycles on FIFO0 give exactly one soft_reset pulse.
    drive(1'b0, 1'b0, 8'h00, 3'b000, 3'b111, 3'b000, 1'b0, 1'b0);
    tick();
    drive(1'b1, 1'b0, 8'h00, 3'b000, 3'b110, 3'b000, 1'b0, 1'b0);
    for (int c = 1; c <= 29; c++) begin
      tick();
      chk($sformatf("idle%0d soft_reset", c), {5'b0, bus.soft_reset}, 8'h00);
    end
    tick();
    chk("idle30 soft_reset pulse", {5'b0, bus.soft_reset}, 8'h01);
    tick();
    chk("idle31 soft_reset drop", {5'b0, bus.soft_reset}, 8'h00);
    // A read at cycle 29 restarts the count, so no pulse follows.
    drive(1'b0, 1'b0, 8'h00, 3'b000, 3'b111, 3'b000, 1'b0, 1'b0);
    tick();
    drive(1'b1, 1'b0, 8'h00, 3'b000, 3'b110, 3'b000, 1'b0, 1'b0);
    for (int c = 1; c <= 40; c++) begin
      bus.read_enb = (c == 29) ? 3'b001 : 3'b000;
      tick();
      chk($sformatf("rdpulse%0d soft_reset", c), {5'b0, bus.soft_reset}, 8'h00);
    end
    // Soft reset of the addressed FIFO aborts a packet stuck in LOAD_DATA.
    drive(1'b0, 1'b0, 8'h00, 3'b000, 3'b111, 3'b000, 1'b0, 1'b0);
    tick();
    drive(1'b1, 1'b1, 8'h00, 3'b000, 3'b111, 3'b000, 1'b0, 1'b0);
    tick();
    chk("ovr lfd", st, S_LFD);
    bus.fifo_empty = 3'b110;
    for (int c = 1; c <= 29; c++) begin
      tick();
      chk($sformatf("ovr ld%0d", c), st, S_LD);
    end
    tick();
    chk("ovr pulse soft_reset", {5'b0, bus.soft_reset}, 8'h01);
    chk("ovr pulse state", st, S_LD);
    bus.pkt_valid = 1'b0;
    tick();
    chk("ovr abort state", st, S_DA);
    chk("ovr abort write_enb", {5'b0, bus.write_enb}, 8'h00);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
